// File: rtl/split_router_if.sv
// split_router_if: five-port flit bundle between a router and its neighbours.
// Ports: data_i/valid_i/ready_o carry input flits in; data_o/valid_o/ready_i carry output flits out.
// Modports: master = traffic environment side, slave = router side.
`ifndef DW
`define DW 16
`endif

interface split_router_if;
  logic [`DW-1:0] data_i  [5];
  logic           valid_i [5];
  logic           ready_o [5];
  logic [`DW-1:0] data_o  [5];
  logic           valid_o [5];
  logic           ready_i [5];

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/split_router.sv
// split_router: forks flits from one selected input port to every masked output port.
// Ports: clk, rstn (async active-low), bus (split_router_if.slave: data_i/valid_i/ready_o in, data_o/valid_o/ready_i out).
// Latency 1 cycle; input stalls only when any masked per-output FIFO is full (registered occupancy).
`ifndef DW
`define DW 16
`endif

module split_router #(
  parameter logic [0:4] input_sel   = 5'b00000,
  parameter logic [0:4] output_mask = 5'b00000,
  parameter int         depth_log   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  split_router_if.slave bus
);

  localparam int depth = 2 ** depth_log;

  // A selector that is zero or has more than one bit set selects nothing.
  localparam logic sel_ok = (input_sel != 5'b00000) &&
                            ((input_sel & (input_sel - 5'd1)) == 5'b00000);
  localparam logic active = sel_ok && (output_mask != 5'b00000);

  logic [0:4]     full;
  logic           in_vld;
  logic [`DW-1:0] in_dat;
  logic           fork_rdy;
  logic           acc;
  logic           unused_bits;

  // Input mux: input_sel is a constant, so this collapses to plain wiring.
  always_comb begin
    in_vld = 1'b0;
    in_dat = '0;
    for (int j = 0; j < 5; j++) begin
      if (input_sel[j]) begin
        in_vld = in_vld | bus.valid_i[j];
        in_dat = in_dat | bus.data_i[j];
      end
    end
  end

  // All-or-nothing fork: accept only if every masked FIFO has room. Uses
  // registered occupancy only, so there is no ready_i -> ready_o path.
  // rstn gating keeps ready_o low for the whole reset window.
  assign fork_rdy = active & rstn & ~(|full);
  assign acc      = in_vld & fork_rdy;

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      bus.ready_o[j] = input_sel[j] & fork_rdy;
    end
  end

  // Inputs on non-selected ports and ready on unmasked outputs are ignored.
  always_comb begin
    unused_bits = 1'b0;
    for (int j = 0; j < 5; j++) begin
      unused_bits = unused_bits ^ bus.valid_i[j] ^ bus.ready_i[j] ^ (^bus.data_i[j]);
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_out
    if (output_mask[i]) begin : g_fifo
      logic [`DW-1:0]       mem [depth];
      logic [depth_log-1:0] wptr;
      logic [depth_log-1:0] rptr;
      logic [depth_log:0]   occ;
      logic                 wr;
      logic                 rd;
      logic                 nonempty;

      assign nonempty = (occ != '0);
      assign wr       = acc;
      assign rd       = nonempty & bus.ready_i[i];
      assign full[i]  = (occ == (depth_log + 1)'(depth));

      // Pointers are depth_log bits wide, so they wrap modulo depth for free.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wptr <= '0;
          rptr <= '0;
          occ  <= '0;
        end else begin
          if (wr) wptr <= wptr + depth_log'(1);
          if (rd) rptr <= rptr + depth_log'(1);
          case ({wr, rd})
            2'b10:   occ <= occ + (depth_log + 1)'(1);
            2'b01:   occ <= occ - (depth_log + 1)'(1);
            default: occ <= occ;
          endcase
        end
      end

      // Storage is not reset; the head is masked to zero whenever the FIFO
      // is empty, which also covers the reset window.
      always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= in_dat;
      end

      assign bus.valid_o[i] = nonempty;
      assign bus.data_o[i]  = nonempty ? mem[rptr] : '0;
    end else begin : g_off
      assign full[i]        = 1'b0;
      assign bus.valid_o[i] = 1'b0;
      assign bus.data_o[i]  = '0;
    end
  end

endmodule

// File: tb/tb_split_router.sv
// tb_split_router: randomized scoreboard bench for split_router (west in, local+east out, depth 4).
// Ports: none; drives clk/rstn and a split_router_if instance.
// Reference: per-output queues of buffered flits; readiness and outputs derived from queue sizes.
`ifndef DW
`define DW 16
`endif

module tb_split_router;

  localparam int WEST  = 1;
  localparam int DEPTH = 4;

  typedef logic [`DW-1:0] flit_q_t [$];

  logic clk;
  logic rstn;
  split_router_if bif ();

  split_router #(
    .input_sel   (5'b01000),
    .output_mask (5'b10100),
    .depth_log   (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  flit_q_t mq [5];          // model: flits buffered for each output, head first
  flit_q_t src_q;           // flits still to be offered on the west port
  bit      model_acc = 0;   // model decision: flit accepted at the coming edge
  bit      offer_en = 0;
  bit      noise_en = 0;
  int      ready_mode [5];  // 0 = hold low, 1 = hold high, 2 = random
  int      n_acc = 0;
  int      delivered [5];
  int      discarded [5];

  function automatic bit is_masked(int i);
    return (i == 0) || (i == 2);
  endfunction

  task automatic chk(string name, int port, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, port, $time, act, exp);
    end
  endtask

  // Monitor then predictor, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit room;
    bit exp_rdy;
    bit exp_vld;
    if (!rstn) begin
      for (int i = 0; i < 5; i++) begin
        discarded[i] += mq[i].size();
        mq[i].delete();
      end
    end
    room = 1'b1;
    for (int i = 0; i < 5; i++)
      if (is_masked(i) && mq[i].size() >= DEPTH) room = 1'b0;
    for (int j = 0; j < 5; j++) begin
      exp_rdy = rstn && (j == WEST) && room;
      chk("ready_o", j, 32'(bif.ready_o[j]), 32'(exp_rdy));
    end
    for (int i = 0; i < 5; i++) begin
      exp_vld = is_masked(i) && (mq[i].size() > 0);
      chk("valid_o", i, 32'(bif.valid_o[i]), 32'(exp_vld));
      chk("data_o", i, 32'(bif.data_o[i]), exp_vld ? 32'(mq[i][0]) : 32'd0);
      if (rstn && bif.valid_o[i] && bif.ready_i[i]) delivered[i]++;
      if (rstn && exp_vld && bif.ready_i[i]) void'(mq[i].pop_front());
    end
    model_acc = rstn && room && bif.valid_i[WEST];
    if (model_acc) begin
      n_acc++;
      for (int i = 0; i < 5; i++)
        if (is_masked(i)) mq[i].push_back(bif.data_i[WEST]);
    end
  end

  // Driver: updates all inputs just after each rising edge.
  initial begin
    logic [`DW-1:0] junk;
    for (int j = 0; j < 5; j++) begin
      bif.valid_i[j] = 1'b0;
      bif.data_i[j]  = '0;
      bif.ready_i[j] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (model_acc && src_q.size() > 0) junk = src_q.pop_front();
      for (int j = 0; j < 5; j++) begin
        if (j == WEST) begin
          bif.valid_i[j] = offer_en && (src_q.size() > 0);
          bif.data_i[j]  = (src_q.size() > 0) ? src_q[0] : `DW'($urandom);
        end else begin
          bif.valid_i[j] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
          bif.data_i[j]  = `DW'($urandom);
        end
        case (ready_mode[j])
          0:       bif.ready_i[j] = 1'b0;
          1:       bif.ready_i[j] = 1'b1;
          default: bif.ready_i[j] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((src_q.size() != 0 || mq[0].size() != 0 || mq[2].size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout waited=%0d limit=%0d", name, n, budget);
    end
  endtask

  task automatic set_ready(int m);
    for (int j = 0; j < 5; j++) ready_mode[j] = m;
  endtask

  initial begin
    int base_acc;
    int base_del;
    int n;
    for (int j = 0; j < 5; j++) begin
      delivered[j] = 0;
      discarded[j] = 0;
    end
    set_ready(1);
    rstn = 1'b0;
    cycles(3);
    rstn = 1'b1;

    // Scenario 1: three flits through both outputs with ready held high.
    src_q = '{16'h000A, 16'h000B, 16'h000C};
    offer_en = 1;
    wait_idle("s1", 50);

    // Scenarios 2/3: east stalled, local draining; east then released while full.
    ready_mode[2] = 0;
    base_acc = n_acc;
    base_del = delivered[0];
    for (int k = 0; k < 6; k++) src_q.push_back(`DW'(16'h0100 + k));
    cycles(12);
    chk("s2_accepted", WEST, 32'(n_acc - base_acc), 32'd4);
    chk("s2_local_rx", 0, 32'(delivered[0] - base_del), 32'd4);
    ready_mode[2] = 1;
    wait_idle("s2", 60);

    // Scenario 4: 20 random flits with random backpressure on each output.
    ready_mode[0] = 2;
    ready_mode[2] = 2;
    for (int k = 0; k < 20; k++) src_q.push_back(`DW'($urandom));
    wait_idle("s4", 400);

    // Scenario 5: reset while three flits are buffered.
    set_ready(0);
    base_acc = n_acc;
    for (int k = 0; k < 3; k++) src_q.push_back(`DW'(16'h0500 + k));
    n = 0;
    while (n_acc - base_acc < 3 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("s5_buffered", WEST, 32'(n_acc - base_acc), 32'd3);
    rstn = 1'b0;
    cycles(2);
    rstn = 1'b1;
    set_ready(1);
    cycles(10);

    // Scenario 6: traffic on non-selected ports, alone and mixed with real flits.
    offer_en = 0;
    noise_en = 1;
    set_ready(2);
    cycles(40);
    offer_en = 1;
    for (int k = 0; k < 12; k++) src_q.push_back(`DW'($urandom));
    wait_idle("s6", 300);
    noise_en = 0;
    cycles(3);

    for (int i = 0; i < 5; i++) begin
      if (is_masked(i))
        chk("delivered_total", i, 32'(delivered[i]), 32'(n_acc - discarded[i]));
      else
        chk("delivered_total", i, 32'(delivered[i]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/split_router.md
SPLIT_ROUTER -- requirements
Module: split_router

Interface
REQ-001 The parameter input_sel SHALL be [0:4], default 0, and is a one-hot selector of the single input port ([0]-local [1]-west [2]-east [3]-north [4]-south).
REQ-002 The parameter output_mask SHALL be [0:4], default 0, where 1 enables replication to that output port (same port order).
REQ-003 The parameter depth_log SHALL have default 2, and each per-output buffer depth SHALL be 2**depth_log.
REQ-004 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-005 The port rstn SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-006 The port data_i[5] SHALL be an input, `DW bits per element, carrying input flits.
REQ-007 The port valid_i[5] SHALL be an input, 1 bit per element, indicating an input flit is valid.
REQ-008 The port ready_o[5] SHALL be an output, 1 bit per element, indicating the input flit is accepted.
REQ-009 The port data_o[5] SHALL be an output, `DW bits per element, carrying output flits.
REQ-010 The port valid_o[5] SHALL be an output, 1 bit per element, indicating an output flit is valid.
REQ-011 The port ready_i[5] SHALL be an input, 1 bit per element, indicating downstream acceptance.

Function
REQ-012 The block SHALL contain one FIFO of width `DW and depth 2**depth_log per output port i with output_mask[i]=1, each with its own write pointer, read pointer and occupancy counter (depth_log+1 bits).
REQ-013 The input accept condition SHALL be acc = valid_i[s] & ready_o[s], where s is the index with input_sel[s]=1.
REQ-014 ready_o[s] SHALL be 1 only when every masked output FIFO is not full (occupancy < 2**depth_log), as an all-or-nothing fork.
REQ-015 ready_o[j] SHALL be constant 0 for every j with input_sel[j]=0.
REQ-016 On acc, data_i[s] SHALL be written unmodified (all `DW bits, header bits included) into every masked FIFO in the same clock edge.
REQ-017 Each masked output i SHALL present its FIFO head first-word-fall-through: valid_o[i] = (occupancy != 0) and data_o[i] = head entry.
REQ-018 Each masked FIFO SHALL be read (read pointer advances, occupancy decrements) on valid_o[i] & ready_i[i], independently of all other outputs.
REQ-019 Latency SHALL be 1 cycle: a flit accepted at edge N appears on valid_o/data_o of every masked output immediately after edge N.
REQ-020 Unmasked outputs SHALL drive valid_o=0 and data_o=0 at all times.
REQ-021 With input_sel=0 or output_mask=0, all ready_o SHALL be 0 and no FIFO SHALL be written.
REQ-022 On a simultaneous write and read of one FIFO, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-023 Full gating SHALL use registered occupancy only: a full FIFO being read in the same cycle SHALL still block input acceptance (no combinational ready_i→ready_o path).
REQ-024 Pointers SHALL wrap modulo 2**depth_log; flit order SHALL be preserved per output.
REQ-025 One slow output SHALL stall input acceptance only once its FIFO is full; other outputs SHALL keep draining their buffered flits.

Reset
REQ-026 While rstn=0, all pointers and occupancy counters SHALL be cleared asynchronously.
REQ-027 While rstn=0, all valid_o SHALL be 0 and all data_o SHALL be 0.
REQ-028 While rstn=0, ready_o SHALL be 0 on every port.
REQ-029 A reset asserted mid-operation SHALL discard all buffered flits; after rstn deasserts, ready_o[s] SHALL be 1 on the first cycle if output_mask≠0.

Verification
REQ-030 Scenario 1: input_sel=west, output_mask=east|local, both ready_i=1, three flits 0xA,0xB,0xC -> each output shows A,B,C, each one cycle after acceptance.
REQ-031 Scenario 2: depth_log=2, east ready_i=0, local ready_i=1, 6 flits offered -> exactly 4 accepted, ready_o[west]=0 from cycle 5; local received those 4; raise east -> 4 drained in order, then remaining 2 accepted.
REQ-032 Scenario 3: FIFO full with read and input valid in the same cycle -> no write that cycle; write occurs the next cycle.
REQ-033 Scenario 4: 20 flits through depth-4 FIFOs with random ready_i per output -> each output sequence equals the input sequence (wrap-around check).
REQ-034 Scenario 5: rstn pulsed low with 3 flits buffered -> valid_o=0 immediately; after release, occupancy is 0 and no stale flit appears.
REQ-035 Scenario 6: valid_i driven on a non-selected port -> its ready_o stays 0 and no output activity occurs.
